dest_demux_d01: RTL

Destination demultiplexer between the virtual-channel FIFO stage and the two destination FIFOs (D0, D1). It pops words from the upstream VC FIFO and routes each word to D0 or D1 according to its destination bit. Each destination FIFO's pause flag back-pressures the routing. Word order is strictly preserved, and a 2-entry output buffer sustains one word per cycle when neither destination is paused.

---
 rtl/dest_demux_d01_if.sv | 56 +++++
 rtl/dest_demux_d01.sv | 124 ++++++++++++
 2 files changed

// File: rtl/dest_demux_d01_if.sv
// dest_demux_d01_if: groups the upstream VC FIFO handshake, the two
// destination FIFO push buses and the status/counter outputs of the
// destination demultiplexer. The slave modport is the demux view, the
// master modport is the surrounding environment (FIFOs or a testbench).
interface dest_demux_d01_if #(
    parameter int DATA_SIZE = 6,
    parameter int CNT_SIZE  = 8
);
    // upstream VC FIFO side
    logic                 vc_empty;
    logic [DATA_SIZE-1:0] vc_data;
    logic                 vc_pop;

    // destination FIFO side
    logic                 pause_d0;
    logic                 pause_d1;
    logic                 push_d0;
    logic                 push_d1;
    logic [DATA_SIZE-1:0] data_d0;
    logic [DATA_SIZE-1:0] data_d1;

    // status
    logic                 demux_idle;
    logic [CNT_SIZE-1:0]  cnt_d0;
    logic [CNT_SIZE-1:0]  cnt_d1;

    modport slave (
        input  vc_empty,
        input  vc_data,
        input  pause_d0,
        input  pause_d1,
        output vc_pop,
        output push_d0,
        output push_d1,
        output data_d0,
        output data_d1,
        output demux_idle,
        output cnt_d0,
        output cnt_d1
    );

    modport master (
        output vc_empty,
        output vc_data,
        output pause_d0,
        output pause_d1,
        input  vc_pop,
        input  push_d0,
        input  push_d1,
        input  data_d0,
        input  data_d1,
        input  demux_idle,
        input  cnt_d0,
        input  cnt_d1
    );
endinterface

// File: rtl/dest_demux_d01.sv
// dest_demux_d01: pops words from the upstream VC FIFO and routes each one
// to destination FIFO D0 or D1 by bit DEST_BIT of the word. A head/skid
// pair plus the in-flight pop keep at most two words buffered, giving one
// word per cycle when neither destination is paused. Strict word order:
// a paused destination blocks the head and therefore all traffic.
// Optional feature: define DEMUX_COUNT_EN to build the per-destination
// forwarded-word counters (wrapping at 2^CNT_SIZE); otherwise they read 0.
module dest_demux_d01 #(
    parameter int DATA_SIZE = 6,
    parameter int DEST_BIT  = 4,
    parameter int CNT_SIZE  = 8
) (
    input  logic           clk,
    input  logic           reset,
    dest_demux_d01_if.slave bus
);

    // buffer state
    logic                 r_inflight;
    logic                 r_head_valid;
    logic [DATA_SIZE-1:0] r_head_data;
    logic                 r_skid_valid;
    logic [DATA_SIZE-1:0] r_skid_data;

    // next-state of the buffer
    logic                 w_head_valid_n;
    logic [DATA_SIZE-1:0] w_head_data_n;
    logic                 w_skid_valid_n;
    logic [DATA_SIZE-1:0] w_skid_data_n;

    // routing and occupancy
    logic                 w_dest;
    logic                 w_push_d0;
    logic                 w_push_d1;
    logic                 w_push;
    logic [1:0]           w_occ;
    logic [1:0]           w_occ_after;
    logic                 w_pop;

    // route the head word and decide whether another pop fits in the buffer
    always_comb begin
        w_dest      = r_head_data[DEST_BIT];
        w_push_d0   = r_head_valid & ~w_dest & ~bus.pause_d0;
        w_push_d1   = r_head_valid &  w_dest & ~bus.pause_d1;
        w_push      = w_push_d0 | w_push_d1;
        w_occ       = {1'b0, r_head_valid} + {1'b0, r_skid_valid} + {1'b0, r_inflight};
        // a push implies head_valid, so this never underflows
        w_occ_after = w_occ - {1'b0, w_push};
        // pop is suppressed while reset is held so nothing is requested upstream
        w_pop       = ~reset & ~bus.vc_empty & (w_occ_after < 2'd2);
    end

    // shift the skid into the head on a push, then land the in-flight word
    // in the first free slot of the post-shift buffer
    always_comb begin
        w_head_valid_n = r_head_valid;
        w_head_data_n  = r_head_data;
        w_skid_valid_n = r_skid_valid;
        w_skid_data_n  = r_skid_data;
        if (w_push) begin
            w_head_valid_n = r_skid_valid;
            w_head_data_n  = r_skid_data;
            w_skid_valid_n = 1'b0;
        end
        if (r_inflight) begin
            if (!w_head_valid_n) begin
                w_head_valid_n = 1'b1;
                w_head_data_n  = bus.vc_data;
            end else begin
                w_skid_valid_n = 1'b1;
                w_skid_data_n  = bus.vc_data;
            end
        end
    end

    // buffer and in-flight registers; reset discards everything in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inflight   <= 1'b0;
            r_head_valid <= 1'b0;
            r_head_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else begin
            r_inflight   <= w_pop;
            r_head_valid <= w_head_valid_n;
            r_head_data  <= w_head_data_n;
            r_skid_valid <= w_skid_valid_n;
            r_skid_data  <= w_skid_data_n;
        end
    end

    assign bus.vc_pop     = w_pop;
    assign bus.push_d0    = w_push_d0;
    assign bus.push_d1    = w_push_d1;
    assign bus.data_d0    = r_head_data;
    assign bus.data_d1    = r_head_data;
    assign bus.demux_idle = (w_occ == 2'd0) & bus.vc_empty;

`ifdef DEMUX_COUNT_EN
    logic [CNT_SIZE-1:0] r_cnt_d0;
    logic [CNT_SIZE-1:0] r_cnt_d1;

    // forwarded-word counters, wrapping naturally at 2^CNT_SIZE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt_d0 <= '0;
            r_cnt_d1 <= '0;
        end else begin
            if (w_push_d0) r_cnt_d0 <= r_cnt_d0 + 1'b1;
            if (w_push_d1) r_cnt_d1 <= r_cnt_d1 + 1'b1;
        end
    end

    assign bus.cnt_d0 = r_cnt_d0;
    assign bus.cnt_d1 = r_cnt_d1;
`else
    logic [CNT_SIZE-1:0] w_cnt_zero;
    assign w_cnt_zero = '0;
    assign bus.cnt_d0 = w_cnt_zero;
    assign bus.cnt_d1 = w_cnt_zero;
`endif

endmodule
